// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display blocks.
//   DIGITS / SEG_W : display geometry
//   GLYPHS         : active-high segment patterns for hex digits 0..F,
//                    bit order {g,f,e,d,c,b,a}. This is the same table the encoder uses.
//   cap_state_e    : capture FSM state encoding
//   onehot_idx     : index of the set bit in a one-hot digit select
package seven_seg_pkg;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 7;

  typedef logic [SEG_W-1:0] glyph_t;

  localparam glyph_t GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } cap_state_e;

  // Only meaningful when exactly one bit of oh is set.
  function automatic logic [1:0] onehot_idx(input logic [DIGITS-1:0] oh);
    onehot_idx = 2'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (oh[k]) onehot_idx = 2'(k);
    end
  endfunction

endpackage

// File: rtl/seven_seg_display_capture_if.sv
// Pin and result bundle for seven_seg_display_capture.
//   master : drives the multiplexed active-low display lines, observes results
//   slave  : the capture block (samples the lines, presents the rebuilt display)
//   an_mux[3:0], seg_mux[6:0], dp_mux : active-low display lines
//   disp_buf[15:0], dp[2:0], digit_valid[3:0], seg_err[3:0], frame_stb, lum_est[3:0] : results
interface seven_seg_display_capture_if;
  import seven_seg_pkg::*;

  logic [DIGITS-1:0]   an_mux;
  logic [SEG_W-1:0]    seg_mux;
  logic                dp_mux;
  logic [4*DIGITS-1:0] disp_buf;
  logic [2:0]          dp;
  logic [DIGITS-1:0]   digit_valid;
  logic [DIGITS-1:0]   seg_err;
  logic                frame_stb;
  logic [3:0]          lum_est;

  modport master (
    output an_mux, seg_mux, dp_mux,
    input  disp_buf, dp, digit_valid, seg_err, frame_stb, lum_est
  );

  modport slave (
    input  an_mux, seg_mux, dp_mux,
    output disp_buf, dp, digit_valid, seg_err, frame_stb, lum_est
  );

endinterface

// File: rtl/seven_seg_display_decoder.sv
// Combinational inverse of the seven-segment glyph table.
//   seg[6:0]    in  : active-high segment pattern
//   legal       out : pattern is one of the 16 hex glyphs
//   nibble[3:0] out : decoded value (0 when not legal)
module seven_seg_display_decoder
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             legal,
  output logic [3:0]       nibble
);

  logic [15:0] hit;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_match
      assign hit[gi] = (seg == GLYPHS[gi]);
    end
  endgenerate

  // Table entries are unique, so at most one hit bit is ever set.
  always_comb begin
    legal  = |hit;
    nibble = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (hit[k]) nibble = 4'(k);
    end
  end

endmodule

// File: rtl/seven_seg_display_capture.sv
// Rebuilds the 4-digit display buffer and decimal-point selector from the
// multiplexed, active-low outputs of a seven-segment display driver.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : an_mux/seg_mux/dp_mux in; disp_buf, dp, digit_valid, seg_err,
//                frame_stb, lum_est out
// Parameters: SETTLE_CYCLES (stable cycles before capture, >=1),
//             LUM_WIN_BITS  (log2 brightness window, >=4).
// Build option: define LUM_MEASURE_EN to build the brightness estimator;
//   otherwise lum_est is tied to 0.
module seven_seg_display_capture
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int LUM_WIN_BITS  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  seven_seg_display_capture_if.slave  bus
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int WORD_W = DIGITS + SEG_W + 1;

  // Two-flop synchronizer; reset to the idle (all lines high) level.
  logic [WORD_W-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= {bus.an_mux, bus.seg_mux, bus.dp_mux};
      sync2_reg <= sync1_reg;
    end
  end

  logic [DIGITS-1:0] an;
  logic [SEG_W-1:0]  seg;
  logic              dpl;
  logic [WORD_W-1:0] cur_word;

  assign {an, seg, dpl} = ~sync2_reg;
  assign cur_word       = {an, seg, dpl};

  // Multi-hot anodes are treated exactly like a blank period.
  logic an_onehot;
  assign an_onehot = (an != '0) && ((an & (an - 1'b1)) == '0);

  logic       dec_legal;
  logic [3:0] dec_nibble;

  seven_seg_display_decoder u_decoder (
    .seg    (seg),
    .legal  (dec_legal),
    .nibble (dec_nibble)
  );

  logic [1:0]        idx;
  logic [DIGITS-1:0] mask_next;
  logic [2:0]        fdp_next;

  assign idx       = onehot_idx(an);
  assign mask_next = frame_mask_reg | an;
  assign fdp_next  = dpl ? (3'(idx) + 3'd1) : frame_dp_reg;

  cap_state_e          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [WORD_W-1:0]   ref_reg;
  logic [DIGITS-1:0]   frame_mask_reg;
  logic [2:0]          frame_dp_reg;
  logic [4*DIGITS-1:0] disp_buf_reg;
  logic [2:0]          dp_reg;
  logic [DIGITS-1:0]   digit_valid_reg;
  logic [DIGITS-1:0]   seg_err_reg;
  logic                frame_stb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      ref_reg         <= '0;
      frame_mask_reg  <= '0;
      frame_dp_reg    <= '0;
      disp_buf_reg    <= '0;
      dp_reg          <= '0;
      digit_valid_reg <= '0;
      seg_err_reg     <= '0;
      frame_stb_reg   <= 1'b0;
    end else begin
      frame_stb_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (an_onehot) begin
            state_reg <= SETTLE;
            cnt_reg   <= '0;
            ref_reg   <= cur_word;
          end
        end
        SETTLE: begin
          if (!an_onehot) begin
            state_reg <= IDLE;
          end else if (cur_word != ref_reg) begin
            ref_reg <= cur_word;
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
            // Pattern has been stable long enough: capture this digit.
            state_reg                     <= HOLD;
            disp_buf_reg[{idx, 2'b00} +: 4] <= dec_legal ? dec_nibble : 4'h0;
            digit_valid_reg[idx]          <= 1'b1;
            seg_err_reg[idx]              <= !dec_legal;
            if (mask_next == '1) begin
              // Frame complete; dp includes this capture's decimal point.
              frame_stb_reg  <= 1'b1;
              dp_reg         <= fdp_next;
              frame_mask_reg <= '0;
              frame_dp_reg   <= '0;
            end else begin
              frame_mask_reg <= mask_next;
              frame_dp_reg   <= fdp_next;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (!an_onehot) begin
            state_reg <= IDLE;
          end else if (cur_word != ref_reg) begin
            state_reg <= SETTLE;
            ref_reg   <= cur_word;
            cnt_reg   <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.disp_buf    = disp_buf_reg;
  assign bus.dp          = dp_reg;
  assign bus.digit_valid = digit_valid_reg;
  assign bus.seg_err     = seg_err_reg;
  assign bus.frame_stb   = frame_stb_reg;

`ifdef LUM_MEASURE_EN
  // Duty-cycle estimate: fraction of a 2^LUM_WIN_BITS window with any anode on,
  // scaled to 0..15 by taking the top four bits of the on-count.
  logic [LUM_WIN_BITS-1:0] win_cnt_reg;
  logic [LUM_WIN_BITS:0]   on_cnt_reg;
  logic [3:0]              lum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_reg <= '0;
      on_cnt_reg  <= '0;
      lum_reg     <= 4'h0;
    end else begin
      win_cnt_reg <= win_cnt_reg + 1'b1;
      if (&win_cnt_reg) begin
        lum_reg    <= on_cnt_reg[LUM_WIN_BITS] ? 4'hF : on_cnt_reg[LUM_WIN_BITS-1 -: 4];
        on_cnt_reg <= '0;
      end else if (|an) begin
        on_cnt_reg <= on_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.lum_est = lum_reg;
`else
  assign bus.lum_est = 4'h0;
`endif

endmodule

// File: tb/tb_seven_seg_display_capture.sv
// Self-checking bench for seven_seg_display_capture: directed scenarios plus
// randomized multiplexed-display traffic, checked against a run-length model.
module tb_seven_seg_display_capture;

  localparam int S  = 4;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_display_capture_if bus ();

  seven_seg_display_capture #(
    .SETTLE_CYCLES (S),
    .LUM_WIN_BITS  (LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Independent glyph table, active-high {g,f,e,d,c,b,a}.
  logic [6:0] tb_glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic [15:0] disp;
    logic [2:0]  dp;
    logic [3:0]  err;
    logic [3:0]  val;
  } frame_t;

  frame_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int frames_seen = 0;

  // Model state
  logic [15:0] m_disp;
  logic [3:0]  m_val, m_err, m_mask;
  logic [2:0]  m_fdp, m_dp;
  logic [11:0] run_word;
  int          run_len;
  bit          run_done;

  function automatic int glyph_value(input logic [6:0] lit);
    for (int k = 0; k < 16; k++) if (tb_glyph[k] == lit) return k;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_disp = '0; m_val = '0; m_err = '0; m_mask = '0; m_fdp = '0; m_dp = '0;
  endtask

  // A digit is captured once per run of identical pin words, as soon as the
  // run has lasted SETTLE_CYCLES+1 cycles with exactly one anode active.
  task automatic set_pins(input logic [3:0] a, input logic [6:0] s, input logic d, input int len);
    logic [11:0] w;
    logic [3:0]  hi;
    int          v;
    int          idx;
    frame_t      f;
    w = {a, s, d};
    if (w == run_word) run_len += len;
    else begin
      run_word = w;
      run_len  = len;
      run_done = 0;
    end
    bus.an_mux  = a;
    bus.seg_mux = s;
    bus.dp_mux  = d;
    hi = ~a;
    if (!run_done && run_len >= S + 1) begin
      run_done = 1;
      if ($countones(hi) == 1) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (hi[k]) idx = k;
        v = glyph_value(~s);
        m_disp[4*idx +: 4] = (v < 0) ? 4'h0 : 4'(v);
        m_val[idx]  = 1'b1;
        m_err[idx]  = (v < 0);
        m_mask[idx] = 1'b1;
        if (!d) m_fdp = 3'(idx + 1);
        if (m_mask == 4'hF) begin
          m_dp   = m_fdp;
          f.disp = m_disp; f.dp = m_fdp; f.err = m_err; f.val = m_val;
          exp_q.push_back(f);
          m_mask = '0;
          m_fdp  = '0;
        end
      end
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int len);
    set_pins(a, s, d, len);
    step(len);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_disp_buf"},    bus.disp_buf,    m_disp);
    check({tag, "_digit_valid"}, bus.digit_valid, m_val);
    check({tag, "_seg_err"},     bus.seg_err,     m_err);
    check({tag, "_dp"},          bus.dp,          m_dp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_disp_buf"},    bus.disp_buf,    0);
    check({tag, "_dp"},          bus.dp,          0);
    check({tag, "_digit_valid"}, bus.digit_valid, 0);
    check({tag, "_seg_err"},     bus.seg_err,     0);
    check({tag, "_frame_stb"},   bus.frame_stb,   0);
    check({tag, "_lum_est"},     bus.lum_est,     0);
  endtask

  function automatic logic [6:0] illegal_glyph();
    logic [6:0] v;
    do v = 7'($urandom_range(0, 127)); while (glyph_value(v) >= 0);
    return v;
  endfunction

  // Monitor: every frame strobe is matched against the next expected frame.
  always @(negedge clk) begin
    if (rst_n && bus.frame_stb) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_stb_unexpected: got 1, expected 0");
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        frames_seen++;
        check("frame_disp_buf",    bus.disp_buf,    e.disp);
        check("frame_dp",          bus.dp,          e.dp);
        check("frame_seg_err",     bus.seg_err,     e.err);
        check("frame_digit_valid", bus.digit_valid, e.val);
        $display("[TB] frame %0d: disp_buf=%h dp=%0d seg_err=%b", frames_seen, bus.disp_buf, bus.dp, bus.seg_err);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [6:0] lit;
    logic       d;
    int         kind, len, i0, i1;

    model_reset();
    run_word = 12'hFFF; run_len = 1000; run_done = 1;
    bus.an_mux = 4'hF; bus.seg_mux = 7'h7F; bus.dp_mux = 1'b1;

    // Reset state
    step(3);
    check_zero("reset_held");
    rst_n = 1'b1;
    step(2);
    check_zero("reset_released");

    // Digit 1 shows '7': captured exactly on edge SETTLE_CYCLES+3
    set_pins(4'b1101, ~7'h07, 1'b1, S + 3);
    step(S + 2);
    check("t2_before_edge", bus.disp_buf[7:4], 4'h0);
    step(1);
    check("t2_nibble",      bus.disp_buf[7:4], 4'h7);
    check("t2_digit_valid", bus.digit_valid,   4'b0010);
    check("t2_frame_stb",   bus.frame_stb,     1'b0);
    drive(4'b1111, 7'h7F, 1'b1, S + 2);

    // Toggling glyph faster than the settle time never captures
    for (int k = 0; k < 10; k++)
      drive(4'b1110, ~tb_glyph[(k % 2) ? 3 : 5], 1'b1, S - 1);
    drive(4'b1111, 7'h7F, 1'b1, S + 3);
    check("t3_nibble0",      bus.disp_buf[3:0], 4'h0);
    check("t3_digit_valid",  bus.digit_valid,   4'b0010);

    // Non-table pattern on digit 2
    drive(4'b1011, ~7'h01, 1'b1, S + 3);
    drive(4'b1111, 7'h7F, 1'b1, S + 3);
    check("t4_seg_err2",     bus.seg_err[2],     1'b1);
    check("t4_nibble2",      bus.disp_buf[11:8], 4'h0);
    check("t4_digit_valid",  bus.digit_valid,    4'b0110);

    // Two anodes active: treated as blank
    drive(4'b1100, ~tb_glyph[1], 1'b1, 100);
    check_state("t5");

    // Driver-style scan of 16'hBEEF with dp on digit 2, two full rounds
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        logic [15:0] beef;
        beef = 16'hBEEF;
        drive(~(4'b0001 << i), ~tb_glyph[beef[4*i +: 4]], (i == 2) ? 1'b0 : 1'b1, S + 3);
        drive(4'b1111, 7'h7F, 1'b1, 2);
      end
    end
    drive(4'b1111, 7'h7F, 1'b1, S + 3);
    check("t1_disp_buf", bus.disp_buf, 16'hBEEF);
    check("t1_dp",       bus.dp,       3'd3);
    check("t1_seg_err",  bus.seg_err,  4'h0);
    check("t1_frames",   frames_seen,  2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 99);
      len  = $urandom_range(1, S + 4);
      if (kind < 12) begin
        drive(bus.an_mux, bus.seg_mux, bus.dp_mux, len);
      end else begin
        if (kind < 22) a = 4'b1111;
        else if (kind < 27) begin
          i0 = $urandom_range(0, 3);
          i1 = (i0 + $urandom_range(1, 3)) % 4;
          a = ~((4'b0001 << i0) | (4'b0001 << i1));
        end else a = ~(4'b0001 << $urandom_range(0, 3));
        lit = ($urandom_range(0, 99) < 85) ? tb_glyph[$urandom_range(0, 15)] : illegal_glyph();
        d   = ($urandom_range(0, 3) == 0);
        drive(a, ~lit, ~d, len);
      end
    end
    drive(4'b1111, 7'h7F, 1'b1, S + 6);
    check_state("rand_end");
    check("rand_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a frame
    drive(4'b1101, ~tb_glyph[9], 1'b1, S + 3);
    drive(4'b1111, 7'h7F, 1'b1, S + 6);
    check("pre_reset_queue", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    model_reset();
    run_done = 1;
    step(2);
    rst_n = 1'b1;
    step(1);

    // Fresh frame after reset
    for (int i = 3; i >= 0; i--)
      drive(~(4'b0001 << i), ~tb_glyph[$urandom_range(0, 15)], (i == 0) ? 1'b0 : 1'b1, S + 2);
    drive(4'b1111, 7'h7F, 1'b1, S + 6);
    check_state("post_reset");
    check("post_reset_dp", bus.dp, 3'd1);

`ifdef LUM_MEASURE_EN
    // 50% anode duty over whole windows -> estimate near 8
    for (int k = 0; k < 48; k++) begin
      drive(4'b1110, ~tb_glyph[8], 1'b1, 8);
      drive(4'b1111, 7'h7F, 1'b1, 8);
    end
    tests++;
    if (bus.lum_est < 4'd7 || bus.lum_est > 4'd9) begin
      fails++;
      $display("FAIL lum_est: got %0d, expected 7..9", bus.lum_est);
    end
`endif

    drive(4'b1111, 7'h7F, 1'b1, S + 6);
    check("final_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
